// File: rtl/seg7_pkg.sv
// Shared constants for the switch-display path: switch width and debounce timing.
// The debounce sample tick reuses the display multiplex period so both blocks share one timebase.
package seg7_pkg;
  localparam int SEG7_MUX_PERIOD       = 100000;
  localparam int SW_WIDTH              = 8;
  localparam int DEBOUNCE_TICK_DIV     = SEG7_MUX_PERIOD;
  localparam int DEBOUNCE_STABLE_TICKS = 8;
endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, tick-qualified mismatch counter and
// debounced level with registered rise/fall strobes.
module debounce_bit
  import seg7_pkg::*;
#(
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic          accept;

  assign mismatch = sync_p1 ^ db;
  assign accept   = tick & mismatch & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      db      <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // Synchronizer stage boundary: raw -> p0 -> p1
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      rise    <= accept & ~db;
      fall    <= accept & db;
      // Any matching sample restarts the run; acceptance also restarts it
      if (tick) begin
        if (!mismatch || (cnt == CNT_LAST))
          cnt <= '0;
        else
          cnt <= cnt + 1'b1;
        if (accept)
          db <= ~db;
      end
    end
  end
endmodule

// File: rtl/switch_debounce.sv
// Switch input conditioning: shared sample-tick prescaler, per-bit debouncers
// and a combined change strobe.
module switch_debounce
  import seg7_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = DEBOUNCE_TICK_DIV,
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic             tick
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else if (div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .tick(tick),
      .raw (sw_raw[i]),
      .db  (sw_db[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end

  // Strobes are already registered, so the OR stays aligned with sw_db
  assign sw_changed = |(sw_rise | sw_fall);
endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with a small tick divider: directed phase table,
// multi-cycle corner sequences and random stimulus against a reference model.
module tb_switch_debounce;
  localparam int TD = 4;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw_raw = 8'h00;
  logic [7:0] sw_db, sw_rise, sw_fall;
  logic       sw_changed, tick;

  switch_debounce #(.WIDTH(8), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_db     (sw_db),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: raw history, edge count since reset, per-bit mismatch runs
  logic [7:0] m_s1 = 8'h00, m_s2 = 8'h00, m_db = 8'h00, m_rise = 8'h00, m_fall = 8'h00;
  int         m_run [8];
  int         m_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] raw);
    logic       t;
    logic [7:0] ndb, nr, nf;
    int         nrun [8];
    rst    = r;
    sw_raw = raw;
    t   = ((m_n % TD) == TD - 1);
    ndb = m_db;
    nr  = 8'h00;
    nf  = 8'h00;
    for (int b = 0; b < 8; b++) begin
      nrun[b] = m_run[b];
      if (t) begin
        if (m_s2[b] == m_db[b]) nrun[b] = 0;
        else if (m_run[b] + 1 >= ST) begin
          nrun[b] = 0;
          ndb[b]  = ~m_db[b];
          if (m_db[b]) nf[b] = 1'b1; else nr[b] = 1'b1;
        end else nrun[b] = m_run[b] + 1;
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_db = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
      m_n = 0;
      for (int b = 0; b < 8; b++) m_run[b] = 0;
    end else begin
      m_s2 = m_s1; m_s1 = raw;
      m_db = ndb; m_rise = nr; m_fall = nf;
      m_n++;
      for (int b = 0; b < 8; b++) m_run[b] = nrun[b];
    end
    chk("sw_db", 32'(sw_db), 32'(m_db));
    chk("sw_rise", 32'(sw_rise), 32'(m_rise));
    chk("sw_fall", 32'(sw_fall), 32'(m_fall));
    chk("sw_changed", 32'(sw_changed), 32'(|(m_rise | m_fall)));
    chk("tick", 32'(tick), 32'((m_n % TD) == TD - 1));
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] raw;
    int         ncyc;
    logic [7:0] db;
    logic [7:0] rise;
    logic [7:0] fall;
    int         chg;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [7:0] acc_r, acc_f, rnd;
    int         chg_cnt, nticks, first_tick;

    for (int b = 0; b < 8; b++) m_run[b] = 0;

    // Phases start on a tick-period boundary; a step held 12 cycles is accepted on its last edge
    tbl[0]  = '{1'b1, 8'hFF,  3, 8'h00, 8'h00, 8'h00, 0};  // reset with switches high
    tbl[1]  = '{1'b0, 8'hFF, 12, 8'hFF, 8'hFF, 8'h00, 1};  // accepted on 3rd tick
    tbl[2]  = '{1'b0, 8'h00, 12, 8'h00, 8'h00, 8'hFF, 1};
    tbl[3]  = '{1'b0, 8'h05, 12, 8'h05, 8'h05, 8'h00, 1};  // clean step
    tbl[4]  = '{1'b0, 8'h05,  8, 8'h05, 8'h00, 8'h00, 0};  // hold: no strobes
    tbl[5]  = '{1'b0, 8'h0D,  8, 8'h05, 8'h00, 8'h00, 0};  // bit3 glitch, 2 ticks
    tbl[6]  = '{1'b0, 8'h05,  8, 8'h05, 8'h00, 8'h00, 0};  // run discarded
    tbl[7]  = '{1'b0, 8'h0D, 12, 8'h0D, 8'h08, 8'h00, 1};  // bit3 accepted
    tbl[8]  = '{1'b0, 8'hF0, 12, 8'hF0, 8'hF0, 8'h0D, 1};
    tbl[9]  = '{1'b0, 8'h0F, 12, 8'h0F, 8'h0F, 8'hF0, 1};  // simultaneous rise/fall
    tbl[10] = '{1'b1, 8'h00,  1, 8'h00, 8'h00, 8'h00, 0};
    tbl[11] = '{1'b0, 8'h01,  8, 8'h00, 8'h00, 8'h00, 0};  // 2 mismatching ticks
    tbl[12] = '{1'b1, 8'h01,  1, 8'h00, 8'h00, 8'h00, 0};  // reset mid-count
    tbl[13] = '{1'b0, 8'h01, 11, 8'h00, 8'h00, 8'h00, 0};  // only 2 ticks since restart
    tbl[14] = '{1'b0, 8'h01,  1, 8'h01, 8'h01, 8'h00, 1};  // 3rd tick accepts

    for (int v = 0; v < 15; v++) begin
      acc_r = 8'h00; acc_f = 8'h00; chg_cnt = 0;
      for (int c = 0; c < tbl[v].ncyc; c++) begin
        step(tbl[v].rst, tbl[v].raw);
        acc_r |= sw_rise;
        acc_f |= sw_fall;
        if (sw_changed) chg_cnt++;
      end
      chk($sformatf("vec%0d_db", v), 32'(sw_db), 32'(tbl[v].db));
      chk($sformatf("vec%0d_rise", v), 32'(acc_r), 32'(tbl[v].rise));
      chk($sformatf("vec%0d_fall", v), 32'(acc_f), 32'(tbl[v].fall));
      chk($sformatf("vec%0d_chg", v), 32'(chg_cnt), 32'(tbl[v].chg));
    end

    // Random bursts of bit flips with occasional resets
    rnd = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) rnd = rnd ^ 8'($urandom);
      step($urandom_range(499) == 0, rnd);
    end

    // Tick cadence from a fresh reset
    step(1'b1, 8'h00);
    nticks = 0;
    first_tick = -1;
    for (int c = 1; c <= 40; c++) begin
      chk($sformatf("cadence_c%0d", c), 32'(tick), 32'((c % TD) == 0));
      if (tick) begin
        nticks++;
        if (first_tick < 0) first_tick = c;
      end
      step(1'b0, 8'h00);
    end
    chk("cadence_count", 32'(nticks), 32'd10);
    chk("cadence_first", 32'(first_tick), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/switch_debounce.md
# switch_debounce

Input-conditioning stage ahead of the 7-segment switch display: takes the 8 raw slide switches and delivers a synchronized, debounced 8-bit value plus one-cycle change strobes. Its `sw_db` output drives the display block's `switch` input directly, so the display never sees metastable or bouncing values. It runs on the same system clock and keeps its own sample-tick prescaler.

## Interface
- `WIDTH`, 8: number of switch bits.
- `TICK_DIV`, 100000: clocks per sample tick; must be ≥ 2.
- `STABLE_TICKS`, 8: consecutive mismatching samples needed to accept a new level; must be ≥ 2.
- `clk`  in  1  system clock; the single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `sw_raw`  in  WIDTH  asynchronous raw switch levels.
- `sw_db`  out  WIDTH  debounced switch value; feeds the display `switch` input.
- `sw_rise`  out  WIDTH  per-bit one-cycle pulse when `sw_db` bit goes 0→1.
- `sw_fall`  out  WIDTH  per-bit one-cycle pulse when `sw_db` bit goes 1→0.
- `sw_changed`  out  1  one-cycle pulse, OR of `sw_rise | sw_fall`.
- `tick`  out  1  sample strobe, exposed for the bench; high one cycle per `TICK_DIV` clocks.

## Operation
- Synchronizer: 2 flops per bit; `sync = sw_raw` delayed by 2 clocks.
- Prescaler: counter `0..TICK_DIV-1`, wraps to 0; `tick` is high while the count equals `TICK_DIV-1`.
- Each bit has its own counter, `$clog2(STABLE_TICKS)` bits wide. On a `tick` cycle:
  - If `sync == sw_db`, the counter clears to 0.
  - Else if the counter equals `STABLE_TICKS-1`, `sw_db` toggles and the counter clears.
  - Else the counter increments.
- When there is no tick, counters and `sw_db` hold.
- A glitch shorter than `STABLE_TICKS` samples is rejected. Any matching sample restarts the count from 0, and the count never carries over between glitches.
- Bits are fully independent. Several bits may toggle on the same tick, giving several rise/fall bits in the same cycle and a single `sw_changed` pulse.
- `sw_rise`, `sw_fall` and `sw_changed` are registered. They are high only in the cycle right after the clock edge that updated `sw_db`, so they coincide with the new `sw_db` value.
- Reset, including mid-count, clears:
  - synchronizer flops, prescaler, all bit counters → 0
  - `sw_db` → 0
  - `sw_rise`, `sw_fall`, `sw_changed`, `tick` → 0
  - The prescaler restarts, so the first tick comes `TICK_DIV` cycles after reset is released.
- If a switch is already high when reset is released, it is accepted after `STABLE_TICKS` ticks. This gives a normal rise pulse.

## Timing
- Reset takes effect on the first `clk` edge where `rst=1`. All outputs are 0 on the next cycle.
- Acceptance latency from a clean `sw_raw` step to the `sw_db` change:
  - minimum: 2 + (`STABLE_TICKS`-1)·`TICK_DIV` + 1 clocks
  - maximum: 2 + `STABLE_TICKS`·`TICK_DIV` clocks
  - which value applies depends on tick phase.
- With defaults at 100 MHz, a tick comes every 1 ms and acceptance takes 7–8 ms.
- Strobes last exactly 1 clock. There is at most one strobe per bit per tick period.
- No handshake; `sw_db` is a level that changes only on tick-qualified edges.

## Structure
- Shared package `seg7_pkg`:
  - `SW_WIDTH` = 8
  - `DEBOUNCE_TICK_DIV` = 100000, which equals the display block's multiplex period constant so the two share one timing definition
  - `DEBOUNCE_STABLE_TICKS` = 8
- Sub-module `debounce_bit`, instantiated `WIDTH` times. It holds one bit's synchronizer, counter and `sw_db`/rise/fall flops, with inputs `clk`, `rst`, `tick`, `raw`.
- The top level contains only the prescaler, the generate loop and the `sw_changed` OR-reduce.

## Test plan
All scenarios use `TICK_DIV`=4 and `STABLE_TICKS`=3.
- Reset: hold `rst` for 3 cycles with `sw_raw`=8'hFF → all outputs 0 during reset. After release, `sw_db` stays 8'h00 until the 3rd tick, then becomes 8'hFF with `sw_rise`=8'hFF and `sw_changed`=1 for one cycle.
- Clean step: `sw_raw` goes from 8'h00 to 8'h05 and holds → `sw_db`=8'h05 after 3 ticks, `sw_rise`=8'h05 for 1 cycle, and no further strobes while the input holds.
- Glitch rejection: bit 3 is high for 2 tick periods, then low → `sw_db` never changes and no strobes occur. Bit 3 then held high for 3 ticks → accepted.
- Simultaneous change: `sw_db`=8'hF0 and `sw_raw` steps to 8'h0F → on the same cycle `sw_db`=8'h0F, `sw_rise`=8'h0F, `sw_fall`=8'hF0, and `sw_changed` pulses once.
- Reset mid-count: after 2 mismatching ticks on bit 0, assert `rst` for 1 cycle → the counter restarts. `sw_db[0]` changes only after 3 further ticks counted from the restarted prescaler.
- Tick cadence: free-run for 40 cycles → `tick` is high exactly 10 times, spaced 4 cycles apart, with the first at cycle 4 after reset release.
